// File: rtl/simple_adder_reg.sv
// Registered 2-bit ripple-carry adder with carry-in, valid-qualified, latency 1 or 2.
// Optional signed-overflow output is enabled by defining SIMPLE_ADDER_REG_OVF_EN.
module simple_adder_reg #(
    parameter int REG_INPUTS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic c0,
    output logic s0,
    output logic s1,
    output logic c2,
    output logic out_vld
`ifdef SIMPLE_ADDER_REG_OVF_EN
    ,
    output logic ovf
`endif
);

    logic op_a0, op_a1, op_b0, op_b1, op_c0;
    logic op_vld;

    generate
        if (REG_INPUTS != 0) begin : g_in_reg
            logic [4:0] opr_q;
            logic       vld_q;

            // NOTE: state is written with <= so every register samples pre-edge values;
            // data registers are reset too, so no stale operand survives reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opr_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= in_vld;
                    if (in_vld) begin
                        opr_q <= {a1, a0, b1, b0, c0};
                    end
                end
            end

            assign {op_a1, op_a0, op_b1, op_b0, op_c0} = opr_q;
            assign op_vld = vld_q;
        end else begin : g_no_reg
            assign {op_a1, op_a0, op_b1, op_b0, op_c0} = {a1, a0, b1, b0, c0};
            assign op_vld = in_vld;
        end
    endgenerate

    logic       k1;
    logic       s0_d, s1_d, c2_d;
    logic [2:0] res_q;
    logic       vld_q;

    // Two explicit full-adder cells; k1 is the internal ripple carry.
    always_comb begin
        s0_d = op_a0 ^ op_b0 ^ op_c0;
        k1   = (op_a0 & op_b0) | (op_a0 & op_c0) | (op_b0 & op_c0);
        s1_d = op_a1 ^ op_b1 ^ k1;
        c2_d = (op_a1 & op_b1) | (op_a1 & k1) | (op_b1 & k1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= op_vld;
            if (op_vld) begin
                res_q <= {c2_d, s1_d, s0_d};
            end
        end
    end

    assign {c2, s1, s0} = res_q;
    assign out_vld      = vld_q;

`ifdef SIMPLE_ADDER_REG_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: operands share a sign bit but the sum's sign differs.
    assign ovf_d = (op_a1 == op_b1) & (s1_d != op_a1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (op_vld) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_simple_adder_reg.sv
// Directed bench for simple_adder_reg: both REG_INPUTS builds side by side on shared inputs.
// Define SIMPLE_ADDER_REG_OVF_EN to also exercise the overflow output.
module tb_simple_adder_reg;

    logic clk;
    logic rst_n;
    logic in_vld, a0, a1, b0, b1, c0;

    logic s0_r, s1_r, c2_r, vld_r;
    logic s0_c, s1_c, c2_c, vld_c;
`ifdef SIMPLE_ADDER_REG_OVF_EN
    logic ovf_r, ovf_c;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    simple_adder_reg #(.REG_INPUTS(1)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0),
        .s0(s0_r), .s1(s1_r), .c2(c2_r), .out_vld(vld_r)
`ifdef SIMPLE_ADDER_REG_OVF_EN
        , .ovf(ovf_r)
`endif
    );

    simple_adder_reg #(.REG_INPUTS(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0),
        .s0(s0_c), .s1(s1_c), .c2(c2_c), .out_vld(vld_c)
`ifdef SIMPLE_ADDER_REG_OVF_EN
        , .ovf(ovf_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] a, input logic [1:0] b, input logic c);
        in_vld = v;
        {a1, a0} = a;
        {b1, b0} = b;
        c0 = c;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [2:0] res_r();
        return {c2_r, s1_r, s0_r};
    endfunction

    function automatic logic [2:0] res_c();
        return {c2_c, s1_c, s0_c};
    endfunction

    // Hand-computed vectors for the back-to-back sequence.
    logic [1:0] seq_a   [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    logic [1:0] seq_b   [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
    logic       seq_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] seq_exp [4] = '{3'd0, 3'd1, 3'd3, 3'd7};

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 2'b00, 2'b00, 1'b0);
        #1;
        check("reset_res_r", res_r(), 3'd0);
        check("reset_vld_r", vld_r, 1'b0);
        check("reset_res_c", res_c(), 3'd0);
        check("reset_vld_c", vld_c, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single vector 1 + 3 + 1 = 5
        set_in(1'b1, 2'b01, 2'b11, 1'b1);
        tick();
        set_in(1'b0, 2'b00, 2'b00, 1'b0);
        check("single_vld_c", vld_c, 1'b1);
        check("single_res_c", res_c(), 3'd5);
        check("single_early_vld_r", vld_r, 1'b0);
        tick();
        check("single_vld_r", vld_r, 1'b1);
        check("single_res_r", res_r(), 3'd5);
        check("single_drop_vld_c", vld_c, 1'b0);
        check("single_hold_c", res_c(), 3'd5);

        // Four back-to-back valid vectors
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, seq_a[i], seq_b[i], seq_c[i]);
            tick();
            check($sformatf("seq%0d_vld_c", i), vld_c, 1'b1);
            check($sformatf("seq%0d_res_c", i), res_c(), seq_exp[i]);
            if (i > 0) begin
                check($sformatf("seq%0d_vld_r", i - 1), vld_r, 1'b1);
                check($sformatf("seq%0d_res_r", i - 1), res_r(), seq_exp[i - 1]);
            end
        end
        set_in(1'b0, 2'b00, 2'b00, 1'b0);
        tick();
        check("seq3_vld_r", vld_r, 1'b1);
        check("seq3_res_r", res_r(), 3'd7);
        check("seq_end_vld_c", vld_c, 1'b0);

        // Bubble/hold: 2 + 1 + 0 = 3, then idle with toggling and unknown operands
        set_in(1'b1, 2'b10, 2'b01, 1'b0);
        tick();
        set_in(1'b0, 2'b11, 2'b11, 1'b1);
        tick();
        check("bubble_vld_r", vld_r, 1'b1);
        check("bubble_res_r", res_r(), 3'd3);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: set_in(1'b0, 2'b01, 2'b10, 1'b0);
                1: set_in(1'b0, 2'bxx, 2'bxx, 1'bx);
                default: set_in(1'b0, 2'b11, 2'b11, 1'b1);
            endcase
            tick();
            check($sformatf("hold%0d_vld_c", k), vld_c, 1'b0);
            check($sformatf("hold%0d_res_c", k), res_c(), 3'd3);
            check($sformatf("hold%0d_vld_r", k), vld_r, 1'b0);
            check($sformatf("hold%0d_res_r", k), res_r(), 3'd3);
        end

        // Exhaustive: all 32 combinations, streamed back to back
        for (int i = 0; i <= 32; i++) begin
            logic [4:0] v, p;
            v = 5'(i);
            p = 5'(i - 1);
            if (i < 32) set_in(1'b1, v[4:3], v[2:1], v[0]);
            else        set_in(1'b0, 2'b00, 2'b00, 1'b0);
            tick();
            if (i < 32) begin
                check($sformatf("exh%0d_vld_c", i), vld_c, 1'b1);
                check($sformatf("exh%0d_res_c", i), res_c(),
                      3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]));
            end
            if (i > 0) begin
                check($sformatf("exh%0d_vld_r", i - 1), vld_r, 1'b1);
                check($sformatf("exh%0d_res_r", i - 1), res_r(),
                      3'(p[4:3]) + 3'(p[2:1]) + 3'(p[0]));
            end
        end
        tick();
        check("exh_end_vld_r", vld_r, 1'b0);

        // Reset mid-stream with in_vld pending
        set_in(1'b1, 2'b11, 2'b11, 1'b1);
        tick();
        check("mid_pre_res_c", res_c(), 3'd7);
        set_in(1'b1, 2'b01, 2'b01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_r", res_r(), 3'd0);
        check("mid_rst_vld_r", vld_r, 1'b0);
        check("mid_rst_res_c", res_c(), 3'd0);
        check("mid_rst_vld_c", vld_c, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst%0d_vld_r", k), vld_r, 1'b0);
            check($sformatf("post_rst%0d_res_r", k), res_r(), 3'd0);
            check($sformatf("post_rst%0d_vld_c", k), vld_c, 1'b0);
        end

`ifdef SIMPLE_ADDER_REG_OVF_EN
        // 1 + 1 = 2 overflows signed 2-bit; -1 + -1 = -2 does not
        set_in(1'b1, 2'b01, 2'b01, 1'b0);
        tick();
        check("ovf1_res_c", res_c(), 3'b010);
        check("ovf1_ovf_c", ovf_c, 1'b1);
        set_in(1'b1, 2'b11, 2'b11, 1'b0);
        tick();
        check("ovf2_res_c", res_c(), 3'b110);
        check("ovf2_ovf_c", ovf_c, 1'b0);
        check("ovf1_res_r", res_r(), 3'b010);
        check("ovf1_ovf_r", ovf_r, 1'b1);
        set_in(1'b0, 2'b01, 2'b01, 1'b0);
        tick();
        check("ovf2_res_r", res_r(), 3'b110);
        check("ovf2_ovf_r", ovf_r, 1'b0);
        check("ovf_hold_c", ovf_c, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
